// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer and the execute-stage ALU.
package mdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REMU = 2'b10,
    OP_RSVD = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DCMP,
    S_DSUB,
    S_DONE
  } mdu_state_e;

  // Must track the execute-stage ALU decoder.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between the execute stage (master) and the MDU sequencer (slave).
interface mdu_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, operand_a, operand_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/alu.sv
// Subset of the shared execute-stage ALU used by the MDU sequencer (add, sub, sltu).
module alu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ctrl,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = '0;
    case (ctrl)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/DIVU/REMU sequencer that borrows the shared ALU (shift-and-add, restoring divide).
// Optional MDU_EARLY_EXIT_EN ends a multiply as soon as the remaining multiplier bits are zero.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  mdu_sequencer_if.slave  req,
  output logic            alu_sel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
);

  localparam int CNT_W = $clog2(MDU_ITER) + 1;
  localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(MDU_ITER);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, divisor_q, divisor_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            alu_sel_q, alu_sel_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;

  logic            accept, div_req, ge;
  logic [XLEN-1:0] rem_sh;

  // ALU operands are registered from the next-state values so they line up with the state that uses them.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    count_d    = count_q;
    result_d   = result_q;
    alu_sel_d  = 1'b0;
    alu_a_d    = '0;
    alu_b_d    = '0;
    alu_ctrl_d = ALU_ADD;
    ge         = 1'b0;
    rem_sh     = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    accept     = req.start && !req.flush && (state_q == S_IDLE || state_q == S_DONE);
    div_req    = (req.op == OP_DIVU) || (req.op == OP_REMU);

    case (state_q)
      S_MUL: begin
        if (mplier_q[0]) acc_d = alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_ONE;
`ifdef MDU_EARLY_EXIT_EN
        if (mplier_d == '0) state_d = S_DONE;
`else
        if (count_d == ITER_CNT) state_d = S_DONE;
`endif
      end
      S_DCMP: begin
        rem_d   = rem_sh;
        quo_d   = quo_q << 1;
        count_d = count_q + CNT_ONE;
        // A bit shifted out of rem means rem_sh exceeds any 32-bit divisor.
        ge      = rem_q[XLEN-1] | ~alu_result[0];
        if (ge)                       state_d = S_DSUB;
        else if (count_d == ITER_CNT) state_d = S_DONE;
      end
      S_DSUB: begin
        rem_d   = alu_result;
        quo_d   = {quo_q[XLEN-1:1], 1'b1};
        state_d = (count_q == ITER_CNT) ? S_DONE : S_DCMP;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      op_d      = req.op;
      acc_d     = '0;
      rem_d     = '0;
      count_d   = '0;
      mcand_d   = req.operand_a;
      mplier_d  = req.operand_b;
      quo_d     = req.operand_a;
      divisor_d = req.operand_b;
      if (div_req && req.operand_b == '0) begin
        quo_d   = '1;
        rem_d   = req.operand_a;
        state_d = S_DONE;
      end else begin
        state_d = div_req ? S_DCMP : S_MUL;
      end
    end

    if (req.flush) state_d = S_IDLE;

    busy_d = (state_d == S_MUL) || (state_d == S_DCMP) || (state_d == S_DSUB);
    done_d = (state_d == S_DONE);
    if (state_d == S_DONE) begin
      case (op_d)
        OP_DIVU: result_d = quo_d;
        OP_REMU: result_d = rem_d;
        default: result_d = acc_d;
      endcase
    end

    case (state_d)
      S_MUL: begin
        alu_sel_d  = 1'b1;
        alu_a_d    = acc_d;
        alu_b_d    = mcand_d;
        alu_ctrl_d = ALU_ADD;
      end
      S_DCMP: begin
        alu_sel_d  = 1'b1;
        alu_a_d    = {rem_d[XLEN-2:0], quo_d[XLEN-1]};
        alu_b_d    = divisor_d;
        alu_ctrl_d = ALU_SLTU;
      end
      S_DSUB: begin
        alu_sel_d  = 1'b1;
        alu_a_d    = rem_d;
        alu_b_d    = divisor_d;
        alu_ctrl_d = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      alu_sel_q  <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      alu_sel_q  <= alu_sel_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  assign req.busy   = busy_q;
  assign req.done   = done_q;
  assign req.result = result_q;
  assign alu_sel    = alu_sel_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer wired to the real alu; expected results and done cycles come from a reference model.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_sel;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;

  always #5 clk = ~clk;

  mdu_sequencer_if #(.XLEN(32)) bus ();

  mdu_sequencer #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (bus),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result)
  );

  alu #(.XLEN(32)) u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .ctrl (alu_ctrl),
    .y    (alu_result)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
    int          exp_cycle;
  } sb_t;

  sb_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cycle      = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] model_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      default: return a * b;
    endcase
  endfunction

  function automatic int model_latency(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    if (op == OP_DIVU || op == OP_REMU) begin
      if (b == 0) return 1;
      return 33 + $countones(a / b);
    end
`ifdef MDU_EARLY_EXIT_EN
    for (int i = 31; i >= 0; i--)
      if (b[i]) return i + 2;
    return 2;
`else
    return 33;
`endif
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(string tag, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    sb.push_back('{tag, model_result(op, a, b), cycle + model_latency(op, a, b)});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDrain(string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    compared++;
    assert (sb.size() == 0)
    else begin
      mismatched++;
      $error("[TB] FAIL %s_timeout: observed %0d pending results, required 0", tag, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Every done pulse must match the oldest outstanding request, in value and in cycle.
  always @(negedge clk) begin
    sb_t e;
    if (!reset && bus.done) begin
      compared++;
      assert (sb.size() > 0)
      else begin
        mismatched++;
        $error("[TB] FAIL unexpected_done: observed done with result 0x%08h, required no done", bus.result);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput({e.tag, "_result"}, bus.result, e.exp);
        checkOutput({e.tag, "_cycle"}, cycle, e.exp_cycle);
        checkOutput({e.tag, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int t0, lat1;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.op        = OP_MUL;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",     {31'b0, bus.busy}, 32'd0);
    checkOutput("rst_done",     {31'b0, bus.done}, 32'd0);
    checkOutput("rst_result",   bus.result,        32'd0);
    checkOutput("rst_alu_sel",  {31'b0, alu_sel},  32'd0);
    checkOutput("rst_alu_a",    alu_a,             32'd0);
    checkOutput("rst_alu_b",    alu_b,             32'd0);
    checkOutput("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'd0);
    reset = 1'b0;

    applyStimulus("mul_7x6", OP_MUL, 32'd7, 32'd6);                    waitDrain("mul_7x6");
    applyStimulus("mul_ovf", OP_MUL, 32'hFFFF_FFFF, 32'd2);            waitDrain("mul_ovf");
    applyStimulus("divu_100_7", OP_DIVU, 32'd100, 32'd7);              waitDrain("divu_100_7");
    applyStimulus("remu_100_7", OP_REMU, 32'd100, 32'd7);              waitDrain("remu_100_7");
    applyStimulus("divu_msb", OP_DIVU, 32'h8000_0001, 32'd1);          waitDrain("divu_msb");
    applyStimulus("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'hC000_0000);  waitDrain("divu_big");
    applyStimulus("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'hC000_0000);  waitDrain("remu_big");
    applyStimulus("remu_div0", OP_REMU, 32'd5, 32'd0);                 waitDrain("remu_div0");
    applyStimulus("divu_div0", OP_DIVU, 32'h1234_5678, 32'd0);         waitDrain("divu_div0");
    applyStimulus("rsvd_op", OP_RSVD, 32'd9, 32'd9);                   waitDrain("rsvd_op");
    applyStimulus("mul_5x3", OP_MUL, 32'd5, 32'd3);                    waitDrain("mul_5x3");
    applyStimulus("mul_5x0", OP_MUL, 32'd5, 32'd0);                    waitDrain("mul_5x0");

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      logic [1:0]  rop;
      rop = 2'($urandom_range(0, 2));
      ra  = $urandom;
      rb  = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      applyStimulus("random", rop, ra, rb);
      waitDrain("random");
    end

    // Reset in the middle of a multiply must abort with no done.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.operand_a = 32'd11; bus.operand_b = 32'hFFFF_0000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midop_busy",     {31'b0, bus.busy}, 32'd1);
    checkOutput("midop_alu_sel",  {31'b0, alu_sel},  32'd1);
    checkOutput("midop_alu_ctrl", {28'b0, alu_ctrl}, {28'b0, ALU_ADD});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_busy",   {31'b0, bus.busy}, 32'd0);
    checkOutput("midrst_result", bus.result,        32'd0);
    repeat (40) @(negedge clk);

    // Flush at T+10 of a multiply, with a simultaneous start that must be dropped.
    applyStimulus("mul_3x5", OP_MUL, 32'd3, 32'd5); waitDrain("mul_3x5");
    @(negedge clk);
    t0 = cycle;
    bus.start = 1'b1; bus.op = OP_MUL; bus.operand_a = 32'h1234; bus.operand_b = 32'hFFFF_FFF0;
    @(negedge clk);
    bus.start = 1'b0;
    while (cycle < t0 + 10) @(negedge clk);
    bus.flush = 1'b1; bus.start = 1'b1; bus.op = OP_DIVU; bus.operand_a = 32'd50; bus.operand_b = 32'd0;
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    checkOutput("flush_busy",    {31'b0, bus.busy}, 32'd0);
    checkOutput("flush_done",    {31'b0, bus.done}, 32'd0);
    checkOutput("flush_result",  bus.result,        32'd15);
    checkOutput("flush_alu_sel", {31'b0, alu_sel},  32'd0);
    repeat (40) @(negedge clk);
    checkOutput("flush_result_held", bus.result, 32'd15);

    // Start held through DONE gives a back-to-back request; starts during busy are ignored.
    @(negedge clk);
    t0 = cycle;
    lat1 = model_latency(OP_MUL, 32'd3, 32'h0001_0000);
    bus.start = 1'b1; bus.op = OP_MUL; bus.operand_a = 32'd3; bus.operand_b = 32'h0001_0000;
    sb.push_back('{"b2b_mul", model_result(OP_MUL, 32'd3, 32'h0001_0000), t0 + lat1});
    while (cycle < t0 + lat1) begin
      @(negedge clk);
      if (cycle == t0 + 5) begin
        bus.op = OP_REMU; bus.operand_a = 32'hDEAD_BEEF; bus.operand_b = 32'd0;
      end
    end
    bus.op = OP_DIVU; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    sb.push_back('{"b2b_divu", model_result(OP_DIVU, 32'd100, 32'd7), cycle + model_latency(OP_DIVU, 32'd100, 32'd7)});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) begin
      repeat (4) @(negedge clk);
      bus.start = 1'b1; bus.op = OP_MUL; bus.operand_a = $urandom; bus.operand_b = $urandom;
      @(negedge clk);
      bus.start = 1'b0;
    end
    waitDrain("b2b");
    repeat (40) @(negedge clk);

    compared++;
    assert (sb.size() == 0)
    else begin
      mismatched++;
      $error("[TB] FAIL final_queue: observed %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
